// File: rtl/nibble_frame_loader_if.sv
// Serial input and decoded-word outputs of the nibble frame loader.
// The master side feeds bits; the slave side is the loader itself.
interface nibble_frame_loader_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CTRL_W = 6
);
  logic              ser_in;
  logic              ser_valid;
  logic [DATA_W-1:0] a_out;
  logic [CTRL_W-1:0] c_out;
  logic              frame_done;
  logic              frame_err;
  logic              busy;

  modport master (
    output ser_in, ser_valid,
    input  a_out, c_out, frame_done, frame_err, busy
  );

  modport slave (
    input  ser_in, ser_valid,
    output a_out, c_out, frame_done, frame_err, busy
  );
endinterface

// File: rtl/nibble_frame_loader.sv
// Deserialises start/data/control/parity frames into registered data and control
// words; any parity error or stall timeout zeroes the control word instead.
module nibble_frame_loader #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned CTRL_W  = 6,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_frame_loader_if.slave bus
);
  localparam int unsigned SHIFT_W = DATA_W + CTRL_W;
  localparam int unsigned CNT_MAX = (DATA_W > CTRL_W) ? DATA_W : CTRL_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   CTRL_LAST  = CNT_W'(CTRL_W - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, CTRL, PARITY} state_e;

  state_e              state_q, state_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [CTRL_W-1:0]   c_q, c_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      par_q   <= 1'b0;
      a_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      par_q   <= par_d;
      a_q     <= a_d;
      c_q     <= c_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    par_d   = par_q;
    a_d     = a_q;
    c_d     = c_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q == IDLE) begin
      stall_d = '0;
      if (bus.ser_valid && bus.ser_in) begin
        state_d = DATA;
        shift_d = '0;
        cnt_d   = '0;
        par_d   = 1'b0;
      end
    end else if (bus.ser_valid) begin
      stall_d = '0;
      unique case (state_q)
        DATA: begin
          shift_d = {shift_q[SHIFT_W-2:0], bus.ser_in};
          par_d   = par_q ^ bus.ser_in;
          if (cnt_q == DATA_LAST) begin
            state_d = CTRL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CTRL: begin
          shift_d = {shift_q[SHIFT_W-2:0], bus.ser_in};
          par_d   = par_q ^ bus.ser_in;
          if (cnt_q == CTRL_LAST) begin
            state_d = PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // Even parity over data+control+parity: accumulator must cancel the parity bit.
          state_d = IDLE;
          if ((par_q ^ bus.ser_in) == 1'b0) begin
            a_d    = shift_q[SHIFT_W-1 -: DATA_W];
            c_d    = shift_q[CTRL_W-1:0];
            done_d = 1'b1;
          end else begin
            c_d   = '0;
            err_d = 1'b1;
          end
        end
      endcase
    end else if (stall_q == STALL_LAST) begin
      // This is the TIMEOUT-th consecutive stall cycle: abandon the frame.
      state_d = IDLE;
      stall_d = '0;
      cnt_d   = '0;
      c_d     = '0;
      err_d   = 1'b1;
    end else begin
      stall_d = stall_q + STALL_W'(1);
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.a_out      = a_q;
  assign bus.c_out      = c_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_nibble_frame_loader.sv
// Scoreboard bench for nibble_frame_loader: each driven frame queues its expected
// strobe outcome, and the output monitor pops and compares it when a strobe appears.
module tb_nibble_frame_loader;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned CTRL_W  = 6;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned SHIFT_W = DATA_W + CTRL_W;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] a;
    logic [CTRL_W-1:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [DATA_W-1:0] model_a;

  always #5 clk = ~clk;

  nibble_frame_loader_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  nibble_frame_loader #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Outputs only move on posedge, so the negedge sees settled values.
  always @(negedge clk) begin
    if (!rst && (bus.frame_done || bus.frame_err)) begin
      exp_t e;
      chk("strobe_exclusive", 32'(bus.frame_done & bus.frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_is_err", 32'(bus.frame_err), 32'(e.err));
        chk("a_out", 32'(bus.a_out), 32'(e.a));
        chk("c_out", 32'(bus.c_out), 32'(e.c));
      end
    end
  end

  task automatic put_bit(input logic v, input logic b, input logic busy_exp_hi);
    @(negedge clk);
    if (busy_exp_hi) chk("busy_in_frame", 32'(bus.busy), 32'd1);
    bus.ser_valid = v;
    bus.ser_in    = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("busy_idle", 32'(bus.busy), 32'd0);
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'($urandom_range(0, 1));
    end
  endtask

  // Drives one frame; stall_at is the payload index before which stall_len idle cycles go.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                            input logic par, input int stall_at, input int stall_len,
                            input logic times_out);
    logic [SHIFT_W-1:0] bits;
    exp_t e;
    bits = {d, c};
    if (times_out || ($countones({d, c, par}) % 2) != 0) begin
      e.err = 1'b1; e.a = model_a; e.c = '0;
    end else begin
      e.err = 1'b0; e.a = d; e.c = c;
      model_a = d;
    end
    exp_q.push_back(e);
    put_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < int'(SHIFT_W); i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) put_bit(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        if (times_out) return;
      end
      put_bit(1'b1, bits[SHIFT_W-1-i], 1'b1);
    end
    put_bit(1'b1, par, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a"}, 32'(bus.a_out), 32'd0);
    chk({tag, "_c"}, 32'(bus.c_out), 32'd0);
    chk({tag, "_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_err"}, 32'(bus.frame_err), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic [CTRL_W-1:0] rc;
    logic [SHIFT_W-1:0] partial;
    model_a       = '0;
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b0;
    rst           = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    check_all_zero("after_idle");

    send_frame(4'hA, 6'h3F, 1'b0, -1, 0, 1'b0);
    idle(3);
    send_frame(4'h3, 6'h3F, 1'b1, -1, 0, 1'b0);
    idle(3);
    send_frame(4'hC, 6'h3E, 1'b1, int'(DATA_W), int'(TIMEOUT) - 1, 1'b0);
    idle(3);
    chk("held_a", 32'(bus.a_out), 32'hC);
    chk("held_c", 32'(bus.c_out), 32'h3E);

    send_frame(4'hC, 6'h3E, 1'b1, int'(DATA_W), int'(TIMEOUT), 1'b1);
    for (int i = 0; i < 6; i++) put_bit(1'b1, 1'b0, 1'b0);
    idle(3);
    chk("timeout_a_held", 32'(bus.a_out), 32'hC);
    chk("timeout_c_zero", 32'(bus.c_out), 32'h0);

    // Back-to-back frames: second start bit lands in the first frame's strobe cycle.
    send_frame(4'h5, 6'h3F, 1'b0, -1, 0, 1'b0);
    send_frame(4'h9, 6'h3F, 1'b0, -1, 0, 1'b0);
    idle(3);

    for (int k = 0; k < 6; k++) begin
      rd = DATA_W'($urandom);
      rc = CTRL_W'($urandom);
      send_frame(rd, rc, 1'($urandom_range(0, 1)), int'($urandom_range(0, SHIFT_W - 1)),
                 int'($urandom_range(0, 3)), 1'b0);
      if (k % 2 == 1) idle(2);
    end
    idle(3);

    // Partial frame (start + data + 3 control bits), then asynchronous reset.
    partial = {4'h6, 6'h3F};
    put_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < int'(DATA_W) + 3; i++) put_bit(1'b1, partial[SHIFT_W-1-i], 1'b1);
    @(negedge clk);
    bus.ser_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    model_a = '0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    send_frame(4'h6, 6'h3F, 1'b0, -1, 0, 1'b0);
    idle(4);
    chk("final_a", 32'(bus.a_out), 32'h6);
    chk("final_c", 32'(bus.c_out), 32'h3F);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
